// File: rtl/rob_module_pkg.sv
// rtl/rob_module_pkg.sv - shared data structures for the reorder buffer
//
// Purpose: global GPR / ROB size defines and the reorder-buffer entry type
// shared by the ROB top, its pointer sub-module and the bus interface.
// Ports: none (package).

`ifndef GPR_IDX_W
`define GPR_IDX_W 5
`endif
`ifndef GPR_W
`define GPR_W 64
`endif
`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif
`ifndef ROB_TAG_SIZE
`define ROB_TAG_SIZE 3
`endif

package rob_module_pkg;

  localparam int ROB_DEPTH_DEF = `ROB_DEPTH;
  localparam int REG_IDX_W_DEF = `GPR_IDX_W;
  localparam int VALUE_W_DEF   = `GPR_W;

  // One reorder-buffer slot. value is only meaningful once done is set.
  typedef struct packed {
    logic                     valid;
    logic                     done;
    logic                     writes_reg;
    logic [REG_IDX_W_DEF-1:0] dst_reg;
    logic [VALUE_W_DEF-1:0]   value;
  } rob_entry_t;

endpackage

// File: rtl/rob_module_if.sv
// rtl/rob_module_if.sv - dispatch / completion / commit bus of the reorder buffer
//
// Purpose: bundles every ROB-facing signal except clock and reset.
// Modports:
//   slave  - the reorder buffer (receives dispatch, lookups, completions, flush)
//   master - the pipeline driving it (dispatch, FUs, flush; consumes commits)

interface rob_module_if
  import rob_module_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int REG_IDX_W = REG_IDX_W_DEF,
  parameter int VALUE_W   = VALUE_W_DEF
) ();

  logic                 in_flush;
  // dispatch allocation
  logic                 in_d_alloc_valid;
  logic                 in_d_writes_reg;
  logic [REG_IDX_W-1:0] in_d_dst_reg;
  logic                 out_d_alloc_ready;
  logic [TAG_W-1:0]     out_d_alloc_tag;
  // dispatch operand lookup
  logic [TAG_W-1:0]     in_d_src1_tag;
  logic [TAG_W-1:0]     in_d_src2_tag;
  logic                 out_d_src1_ready;
  logic [VALUE_W-1:0]   out_d_src1_value;
  logic                 out_d_src2_ready;
  logic [VALUE_W-1:0]   out_d_src2_value;
  // functional-unit completion
  logic                 in_fu_done_valid;
  logic [TAG_W-1:0]     in_fu_done_tag;
  logic [VALUE_W-1:0]   in_fu_done_value;
  // register-file commit and status
  logic                 out_rob_should_commit;
  logic [VALUE_W-1:0]   out_rob_commit_value;
  logic [REG_IDX_W-1:0] out_rob_regfile_index;
  logic                 out_retire_valid;
  logic [TAG_W:0]       out_count;
  logic                 out_empty;

  modport slave (
    input  in_flush,
    input  in_d_alloc_valid, in_d_writes_reg, in_d_dst_reg,
    output out_d_alloc_ready, out_d_alloc_tag,
    input  in_d_src1_tag, in_d_src2_tag,
    output out_d_src1_ready, out_d_src1_value, out_d_src2_ready, out_d_src2_value,
    input  in_fu_done_valid, in_fu_done_tag, in_fu_done_value,
    output out_rob_should_commit, out_rob_commit_value, out_rob_regfile_index,
    output out_retire_valid, out_count, out_empty
  );

  modport master (
    output in_flush,
    output in_d_alloc_valid, in_d_writes_reg, in_d_dst_reg,
    input  out_d_alloc_ready, out_d_alloc_tag,
    output in_d_src1_tag, in_d_src2_tag,
    input  out_d_src1_ready, out_d_src1_value, out_d_src2_ready, out_d_src2_value,
    output in_fu_done_valid, in_fu_done_tag, in_fu_done_value,
    input  out_rob_should_commit, out_rob_commit_value, out_rob_regfile_index,
    input  out_retire_valid, out_count, out_empty
  );

endinterface

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrap-bit circular-buffer pointer with increment and clear
//
// Purpose: W-bit pointer whose MSB is the wrap bit; counts modulo 2**W.
// Ports:
//   clk  - clock
//   clr  - synchronous clear to 0, wins over inc
//   inc  - advance by one
//   ptr  - current pointer value (index bits plus wrap bit)

module rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rob_module.sv
// rtl/rob_module.sv - reorder buffer feeding the register-file commit port
//
// Purpose: allocates entries in program order, accepts out-of-order FU
// completions by tag, retires at most the oldest completed entry per cycle
// and drives the registered GPR commit outputs. Also answers two operand
// lookups per cycle with same-cycle completion bypass.
// Ports:
//   in_clk - clock
//   in_rst - synchronous active-high reset
//   bus    - rob_module_if.slave: flush, dispatch alloc/lookup, FU completion,
//            commit outputs, occupancy status

module rob_module
  import rob_module_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int REG_IDX_W = REG_IDX_W_DEF,
  parameter int VALUE_W   = VALUE_W_DEF
) (
  input  logic          in_clk,
  input  logic          in_rst,
  rob_module_if.slave   bus
);

  rob_entry_t entries [ROB_DEPTH];

  logic [TAG_W:0]   head_ptr;
  logic [TAG_W:0]   tail_ptr;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             clr;
  logic             full;
  logic             alloc;
  logic             retire;
  logic             complete;
  rob_entry_t       head_entry;

  logic                 retire_valid_q;
  logic                 should_commit_q;
  logic [VALUE_W-1:0]   commit_value_q;
  logic [REG_IDX_W-1:0] commit_index_q;

  assign clr      = in_rst || bus.in_flush;
  assign head_idx = head_ptr[TAG_W-1:0];
  assign tail_idx = tail_ptr[TAG_W-1:0];

  // Same slot index but opposite wrap bits means the tail has lapped the head.
  assign full = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);

  // Allocation looks only at this cycle's occupancy, so a full buffer refuses
  // even when the head is retiring on the same edge.
  assign alloc = bus.in_d_alloc_valid && !full;

  // Retirement uses registered done state only: an entry completed on edge N
  // becomes retirable on edge N+1.
  assign head_entry = entries[head_idx];
  assign retire     = head_entry.valid && head_entry.done;

  assign complete = bus.in_fu_done_valid && entries[bus.in_fu_done_tag].valid;

  rob_ptr #(.W(TAG_W + 1)) u_head_ptr (
    .clk (in_clk),
    .clr (clr),
    .inc (retire),
    .ptr (head_ptr)
  );

  rob_ptr #(.W(TAG_W + 1)) u_tail_ptr (
    .clk (in_clk),
    .clr (clr),
    .inc (alloc),
    .ptr (tail_ptr)
  );

  always_ff @(posedge in_clk) begin
    if (clr) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries[i] <= '0;
      end
      retire_valid_q  <= 1'b0;
      should_commit_q <= 1'b0;
      commit_value_q  <= '0;
      commit_index_q  <= '0;
    end else begin
      retire_valid_q  <= retire;
      should_commit_q <= retire && head_entry.writes_reg;
      if (retire) begin
        commit_value_q <= head_entry.value;
        commit_index_q <= head_entry.dst_reg;
      end

      // A repeat completion to a done entry simply overwrites the value.
      if (complete) begin
        entries[bus.in_fu_done_tag].done  <= 1'b1;
        entries[bus.in_fu_done_tag].value <= bus.in_fu_done_value;
      end

      // Placed after the completion so a late completion to the retiring
      // head cannot leave a stale done bit behind.
      if (retire) begin
        entries[head_idx].valid <= 1'b0;
        entries[head_idx].done  <= 1'b0;
      end

      // The tail slot is never valid when alloc fires, so this cannot
      // collide with a completion or the retirement above.
      if (alloc) begin
        entries[tail_idx].valid      <= 1'b1;
        entries[tail_idx].done       <= 1'b0;
        entries[tail_idx].writes_reg <= bus.in_d_writes_reg;
        entries[tail_idx].dst_reg    <= bus.in_d_dst_reg;
        entries[tail_idx].value      <= '0;
      end
    end
  end

  // Operand lookup: a completion arriving this cycle is forwarded directly.
  rob_entry_t src1_entry;
  rob_entry_t src2_entry;
  logic       src1_bypass;
  logic       src2_bypass;

  assign src1_entry  = entries[bus.in_d_src1_tag];
  assign src2_entry  = entries[bus.in_d_src2_tag];
  assign src1_bypass = bus.in_fu_done_valid && (bus.in_fu_done_tag == bus.in_d_src1_tag);
  assign src2_bypass = bus.in_fu_done_valid && (bus.in_fu_done_tag == bus.in_d_src2_tag);

  assign bus.out_d_src1_ready = src1_entry.valid && (src1_entry.done || src1_bypass);
  assign bus.out_d_src2_ready = src2_entry.valid && (src2_entry.done || src2_bypass);
  assign bus.out_d_src1_value = !src1_entry.valid ? '0 :
                                src1_bypass       ? bus.in_fu_done_value : src1_entry.value;
  assign bus.out_d_src2_value = !src2_entry.valid ? '0 :
                                src2_bypass       ? bus.in_fu_done_value : src2_entry.value;

  assign bus.out_d_alloc_ready     = !full;
  assign bus.out_d_alloc_tag       = tail_idx;
  assign bus.out_rob_should_commit = should_commit_q;
  assign bus.out_rob_commit_value  = commit_value_q;
  assign bus.out_rob_regfile_index = commit_index_q;
  assign bus.out_retire_valid      = retire_valid_q;
  // Modular difference of wrap-bit pointers is exactly the occupancy.
  assign bus.out_count             = tail_ptr - head_ptr;
  assign bus.out_empty             = (head_ptr == tail_ptr);

endmodule

// File: tb/tb_rob_module.sv
// tb/tb_rob_module.sv - scoreboard testbench for rob_module

module tb_rob_module;
  import rob_module_pkg::*;

  localparam int DEPTH = 8;
  localparam int TW    = 3;
  localparam int RW    = 5;
  localparam int VW    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rob_module_if #(.ROB_DEPTH(DEPTH), .TAG_W(TW), .REG_IDX_W(RW), .VALUE_W(VW)) bus ();

  rob_module #(.ROB_DEPTH(DEPTH), .TAG_W(TW), .REG_IDX_W(RW), .VALUE_W(VW)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sc;
    logic [RW-1:0] idx;
    logic [VW-1:0] val;
  } exp_t;

  exp_t exq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic sc, input int idx, input logic [63:0] val);
    exp_t e;
    e.sc  = sc;
    e.idx = RW'(idx);
    e.val = val;
    exq.push_back(e);
  endtask

  task automatic idle();
    bus.in_flush         = 1'b0;
    bus.in_d_alloc_valid = 1'b0;
    bus.in_d_writes_reg  = 1'b0;
    bus.in_d_dst_reg     = '0;
    bus.in_d_src1_tag    = '0;
    bus.in_d_src2_tag    = '0;
    bus.in_fu_done_valid = 1'b0;
    bus.in_fu_done_tag   = '0;
    bus.in_fu_done_value = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_alloc(input logic v, input logic wr, input int dst);
    bus.in_d_alloc_valid = v;
    bus.in_d_writes_reg  = wr;
    bus.in_d_dst_reg     = RW'(dst);
  endtask

  task automatic set_done(input logic v, input int tag, input logic [63:0] val);
    bus.in_fu_done_valid = v;
    bus.in_fu_done_tag   = TW'(tag);
    bus.in_fu_done_value = val;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && !bus.out_empty; i++) step();
    chk({name, "_empty"}, 64'(bus.out_empty), 64'd1);
    step();
    chk({name, "_queue"}, 64'(exq.size()), 64'd0);
  endtask

  // Monitor: every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_retire_valid === 1'b1) begin
      if (exq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_retire: idx %0d val %0h want no retire",
                 bus.out_rob_regfile_index, bus.out_rob_commit_value);
      end else begin
        e = exq.pop_front();
        chk("commit_sc",  64'(bus.out_rob_should_commit), 64'(e.sc));
        chk("commit_idx", 64'(bus.out_rob_regfile_index), 64'(e.idx));
        chk("commit_val", bus.out_rob_commit_value,       e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_count", 64'(bus.out_count), 64'd0);
    chk("rst_empty", 64'(bus.out_empty), 64'd1);
    chk("rst_ready", 64'(bus.out_d_alloc_ready), 64'd1);
    chk("rst_tag",   64'(bus.out_d_alloc_tag), 64'd0);
    chk("rst_retire", 64'(bus.out_retire_valid), 64'd0);
    chk("rst_sc",    64'(bus.out_rob_should_commit), 64'd0);
    chk("rst_val",   bus.out_rob_commit_value, 64'd0);
    chk("rst_idx",   64'(bus.out_rob_regfile_index), 64'd0);

    // Three allocations, then out-of-order completion, in-order commit
    for (int k = 0; k < 3; k++) begin
      set_alloc(1'b1, 1'b1, k + 1);
      chk("t1_tag", 64'(bus.out_d_alloc_tag), 64'(k));
      step();
    end
    set_alloc(1'b0, 1'b0, 0);
    chk("t1_count", 64'(bus.out_count), 64'd3);
    chk("t1_empty", 64'(bus.out_empty), 64'd0);

    set_done(1'b1, 2, 64'd30);
    step();
    set_done(1'b1, 1, 64'd20);
    step();
    push_exp(1'b1, 1, 64'd10);
    push_exp(1'b1, 2, 64'd20);
    push_exp(1'b1, 3, 64'd30);
    set_done(1'b1, 0, 64'd10);
    step();
    set_done(1'b0, 0, 64'd0);
    chk("t2_no_early_retire", 64'(bus.out_retire_valid), 64'd0);
    step();
    chk("t2_first_retire", 64'(bus.out_retire_valid), 64'd1);
    drain("t2");
    chk("t2_hold_retire", 64'(bus.out_retire_valid), 64'd0);
    chk("t2_hold_val", bus.out_rob_commit_value, 64'd30);
    chk("t2_hold_idx", 64'(bus.out_rob_regfile_index), 64'd3);

    // Fill to full, refused allocation, wrap of the tail
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      set_alloc(1'b1, 1'b1, 8 + k);
      chk("t3_tag", 64'(bus.out_d_alloc_tag), 64'(k));
      step();
    end
    chk("t3_full_count", 64'(bus.out_count), 64'd8);
    chk("t3_full_ready", 64'(bus.out_d_alloc_ready), 64'd0);
    set_alloc(1'b1, 1'b0, 20);
    step();
    chk("t3_refused_count", 64'(bus.out_count), 64'd8);
    push_exp(1'b1, 8, 64'h100);
    set_done(1'b1, 0, 64'h100);
    step();
    set_done(1'b0, 0, 64'd0);
    chk("t3_still_full", 64'(bus.out_d_alloc_ready), 64'd0);
    step();
    chk("t3_retire_cycle_count", 64'(bus.out_count), 64'd7);
    chk("t3_ready_after", 64'(bus.out_d_alloc_ready), 64'd1);
    chk("t3_wrap_tag", 64'(bus.out_d_alloc_tag), 64'd0);
    step();
    set_alloc(1'b0, 1'b0, 0);
    chk("t3_count_back", 64'(bus.out_count), 64'd8);

    // Drain, last entry has writes_reg=0
    for (int k = 1; k < DEPTH; k++) begin
      push_exp(1'b1, 8 + k, 64'h200 + 64'(k));
      set_done(1'b1, k, 64'h200 + 64'(k));
      step();
    end
    push_exp(1'b0, 20, 64'h55);
    set_done(1'b1, 0, 64'h55);
    step();
    set_done(1'b0, 0, 64'd0);
    drain("t4");

    // Lookup with same-cycle bypass, invalid tag
    do_reset();
    set_alloc(1'b1, 1'b1, 4);
    step();
    set_alloc(1'b1, 1'b1, 5);
    step();
    set_alloc(1'b0, 1'b0, 0);
    bus.in_d_src1_tag = TW'(1);
    bus.in_d_src2_tag = TW'(3);
    set_done(1'b1, 1, 64'hABCD);
    #1;
    chk("t5_byp_ready", 64'(bus.out_d_src1_ready), 64'd1);
    chk("t5_byp_value", bus.out_d_src1_value, 64'hABCD);
    chk("t5_inv_ready", 64'(bus.out_d_src2_ready), 64'd0);
    chk("t5_inv_value", bus.out_d_src2_value, 64'd0);
    step();
    set_done(1'b0, 0, 64'd0);
    bus.in_d_src2_tag = TW'(0);
    #1;
    chk("t5_stored_ready", 64'(bus.out_d_src1_ready), 64'd1);
    chk("t5_stored_value", bus.out_d_src1_value, 64'hABCD);
    chk("t5_notdone_ready", 64'(bus.out_d_src2_ready), 64'd0);
    push_exp(1'b1, 4, 64'h44);
    push_exp(1'b1, 5, 64'hABCD);
    set_done(1'b1, 0, 64'h44);
    step();
    set_done(1'b0, 0, 64'd0);
    drain("t5");

    // Flush with simultaneous alloc and completion
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_alloc(1'b1, 1'b1, k + 1);
      step();
    end
    set_alloc(1'b0, 1'b0, 0);
    set_done(1'b1, 1, 64'h11);
    step();
    set_done(1'b1, 2, 64'h22);
    step();
    chk("t6_pre_count", 64'(bus.out_count), 64'd4);
    bus.in_flush = 1'b1;
    set_alloc(1'b1, 1'b1, 9);
    set_done(1'b1, 0, 64'h9);
    step();
    idle();
    chk("t6_count", 64'(bus.out_count), 64'd0);
    chk("t6_empty", 64'(bus.out_empty), 64'd1);
    chk("t6_retire", 64'(bus.out_retire_valid), 64'd0);
    chk("t6_sc", 64'(bus.out_rob_should_commit), 64'd0);
    chk("t6_tag", 64'(bus.out_d_alloc_tag), 64'd0);
    set_alloc(1'b1, 1'b1, 7);
    chk("t6_alloc_tag", 64'(bus.out_d_alloc_tag), 64'd0);
    step();
    set_alloc(1'b0, 1'b0, 0);
    chk("t6_post_count", 64'(bus.out_count), 64'd1);
    bus.in_d_src1_tag = TW'(0);
    bus.in_d_src2_tag = TW'(5);
    set_done(1'b1, 5, 64'h77);
    step();
    set_done(1'b0, 0, 64'd0);
    chk("t6_notdone", 64'(bus.out_d_src1_ready), 64'd0);
    chk("t6_inv_done_ignored", 64'(bus.out_d_src2_ready), 64'd0);
    chk("t6_inv_count", 64'(bus.out_count), 64'd1);
    step();
    step();
    chk("t6_queue", 64'(exq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
